// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared register-index constants and lane-slice helpers for the issue pipeline
package cpu_pipe_pkg;
    localparam int REG_W = 5;
    localparam int NREGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_PAYLOAD_W = 160;

    typedef logic [REG_W-1:0] reg_idx_t;

    function automatic int reg_off(input int lane);
        return lane * REG_W;
    endfunction
endpackage

// File: rtl/regfile_mp.sv
// regfile_mp: 32-entry register file, LANES write ports, 2*LANES comb read ports
// Writes are visible to same-cycle reads; on colliding writes the highest lane wins.
module regfile_mp
    import cpu_pipe_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0]          we,
    input  logic [LANES*REG_W-1:0]    waddr,
    input  logic [LANES*XLEN-1:0]     wdata,
    input  logic [2*LANES*REG_W-1:0]  raddr,
    output logic [2*LANES*XLEN-1:0]   rdata
);
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                if (we[l] && waddr[reg_off(l) +: REG_W] != REG_ZERO)
                    mem[waddr[reg_off(l) +: REG_W]] <= wdata[l*XLEN +: XLEN];
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < 2*LANES; p++) begin
            if (raddr[reg_off(p) +: REG_W] != REG_ZERO) begin
                rdata[p*XLEN +: XLEN] = mem[raddr[reg_off(p) +: REG_W]];
                for (int l = 0; l < LANES; l++)
                    if (we[l] && waddr[reg_off(l) +: REG_W] == raddr[reg_off(p) +: REG_W])
                        rdata[p*XLEN +: XLEN] = wdata[l*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: rtl/reg_ex_issue_stage.sv
// reg_ex_issue_stage: ID->EX register with operand read, load-use scoreboard and held-operand forwarding
module reg_ex_issue_stage
    import cpu_pipe_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int LOAD_LAT  = DEF_LOAD_LAT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      forward_stall,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [LANES-1:0]          id_lane_valid,
    input  logic [LANES*PAYLOAD_W-1:0] id_payload,
    input  logic [LANES*REG_W-1:0]    id_rj,
    input  logic [LANES*REG_W-1:0]    id_rk,
    input  logic [LANES*REG_W-1:0]    id_rd,
    input  logic [LANES-1:0]          id_we,
    input  logic [LANES-1:0]          id_is_load,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [LANES-1:0]          ex_lane_valid,
    output logic [LANES*PAYLOAD_W-1:0] ex_payload,
    output logic [LANES*REG_W-1:0]    ex_rj,
    output logic [LANES*REG_W-1:0]    ex_rk,
    output logic [LANES*REG_W-1:0]    ex_rd,
    output logic [LANES-1:0]          ex_we,
    output logic [LANES-1:0]          ex_is_load,
    output logic [LANES*XLEN-1:0]     ex_rj_data,
    output logic [LANES*XLEN-1:0]     ex_rk_data,
    input  logic [LANES-1:0]          fwd_j_valid,
    input  logic [LANES-1:0]          fwd_k_valid,
    input  logic [LANES*XLEN-1:0]     fwd_j_data,
    input  logic [LANES*XLEN-1:0]     fwd_k_data,
    input  logic [LANES-1:0]          wb_we,
    input  logic [LANES*REG_W-1:0]    wb_addr,
    input  logic [LANES*XLEN-1:0]     wb_data
);
    localparam int DW = LANES * XLEN;

    logic adv, hazard, take, ex_clr;
    logic [NREGS-1:0] busy, sb_busy;
    logic [2*DW-1:0] rf_rdata;

    regfile_mp #(.LANES(LANES), .XLEN(XLEN)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (wb_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .raddr ({id_rk, id_rj}),
        .rdata (rf_rdata)
    );

    assign adv      = ex_ready & ~forward_stall;
    assign id_ready = adv & ~hazard;
    assign take     = id_valid & id_ready;
    // Flush waits for adv while valid contents are held; bubbles clear the same fields.
    assign ex_clr   = reset | (flush & (adv | ~ex_valid)) | (adv & ~take);

    // A register is busy while a load targeting it sits in EX or in the load shadow.
    always_comb begin
        busy   = sb_busy;
        hazard = 1'b0;
        for (int l = 0; l < LANES; l++)
            if (ex_valid && ex_is_load[l] && ex_we[l]) busy[ex_rd[reg_off(l) +: REG_W]] = 1'b1;
        busy[REG_ZERO] = 1'b0;
        for (int l = 0; l < LANES; l++)
            hazard = hazard | (id_lane_valid[l] & (busy[id_rj[reg_off(l) +: REG_W]] | busy[id_rk[reg_off(l) +: REG_W]]));
    end

    always_ff @(posedge clk) begin
        if (ex_clr) begin
            ex_valid      <= 1'b0;
            ex_lane_valid <= '0;
            ex_payload    <= '0;
            ex_rj         <= '0;
            ex_rk         <= '0;
            ex_rd         <= '0;
            ex_we         <= '0;
            ex_is_load    <= '0;
            ex_rj_data    <= '0;
            ex_rk_data    <= '0;
        end else if (take) begin
            ex_valid      <= 1'b1;
            ex_lane_valid <= id_lane_valid;
            ex_payload    <= id_payload;
            ex_rj         <= id_rj;
            ex_rk         <= id_rk;
            ex_rd         <= id_rd;
            ex_we         <= id_we;
            ex_is_load    <= id_is_load;
            ex_rj_data    <= rf_rdata[DW-1:0];
            ex_rk_data    <= rf_rdata[2*DW-1:DW];
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (fwd_j_valid[l]) ex_rj_data[l*XLEN +: XLEN] <= fwd_j_data[l*XLEN +: XLEN];
                if (fwd_k_valid[l]) ex_rk_data[l*XLEN +: XLEN] <= fwd_k_data[l*XLEN +: XLEN];
            end
        end
    end

    generate
        if (LOAD_LAT > 0) begin : g_sb
            logic [LOAD_LAT-1:0][LANES-1:0]            sb_v;
            logic [LOAD_LAT-1:0][LANES-1:0][REG_W-1:0] sb_rd;

            // Shifts only on adv so stalls stretch the load shadow; flush leaves it intact.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sb_v  <= '0;
                    sb_rd <= '0;
                end else if (adv) begin
                    for (int l = 0; l < LANES; l++) begin
                        sb_v[0][l]  <= ex_lane_valid[l] & ex_is_load[l] & ex_we[l] & (ex_rd[reg_off(l) +: REG_W] != REG_ZERO);
                        sb_rd[0][l] <= ex_rd[reg_off(l) +: REG_W];
                    end
                    for (int k = 1; k < LOAD_LAT; k++) begin
                        sb_v[k]  <= sb_v[k-1];
                        sb_rd[k] <= sb_rd[k-1];
                    end
                end
            end

            always_comb begin
                sb_busy = '0;
                for (int k = 0; k < LOAD_LAT; k++)
                    for (int l = 0; l < LANES; l++)
                        if (sb_v[k][l]) sb_busy[sb_rd[k][l]] = 1'b1;
            end
        end else begin : g_no_sb
            assign sb_busy = '0;
        end
    endgenerate
endmodule

// File: tb/tb_reg_ex_issue_stage.sv
// tb_reg_ex_issue_stage: vector table, directed corner cases and a random run against a reference model
module tb_reg_ex_issue_stage;
    localparam int L = 2, X = 32, P = 160, LL = 2;

    logic clk = 1'b0;
    logic reset, flush, forward_stall, id_valid, id_ready, ex_valid, ex_ready;
    logic [L-1:0] id_lane_valid, id_we, id_is_load, ex_lane_valid, ex_we, ex_is_load;
    logic [L-1:0] fwd_j_valid, fwd_k_valid, wb_we;
    logic [L*P-1:0] id_payload, ex_payload;
    logic [L*5-1:0] id_rj, id_rk, id_rd, ex_rj, ex_rk, ex_rd, wb_addr;
    logic [L*X-1:0] ex_rj_data, ex_rk_data, fwd_j_data, fwd_k_data, wb_data;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    reg_ex_issue_stage #(.LANES(L), .XLEN(X), .PAYLOAD_W(P), .LOAD_LAT(LL)) dut (
        .clk(clk), .reset(reset), .flush(flush), .forward_stall(forward_stall),
        .id_valid(id_valid), .id_ready(id_ready), .id_lane_valid(id_lane_valid),
        .id_payload(id_payload), .id_rj(id_rj), .id_rk(id_rk), .id_rd(id_rd),
        .id_we(id_we), .id_is_load(id_is_load),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_lane_valid(ex_lane_valid),
        .ex_payload(ex_payload), .ex_rj(ex_rj), .ex_rk(ex_rk), .ex_rd(ex_rd),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rj_data(ex_rj_data), .ex_rk_data(ex_rk_data),
        .fwd_j_valid(fwd_j_valid), .fwd_k_valid(fwd_k_valid),
        .fwd_j_data(fwd_j_data), .fwd_k_data(fwd_k_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    // Reference model: architectural registers, EX contents, loads still in their shadow.
    typedef struct { logic [4:0] rd; int left; } ld_t;
    typedef struct { logic [4:0] rj, rk; logic [X-1:0] ej, ek; } vec_t;
    logic [X-1:0] rf [32];
    logic m_valid;
    logic [L-1:0] m_lv, m_we, m_ld;
    logic [L*P-1:0] m_pl;
    logic [L*5-1:0] m_rj, m_rk, m_rd;
    logic [L*X-1:0] m_jd, m_kd;
    ld_t infl[$];
    vec_t tbl[5];
    logic [L*P-1:0] saved_pl;

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [X-1:0] read_reg(input logic [4:0] a);
        logic [X-1:0] v;
        v = (a == 0) ? '0 : rf[a];
        for (int l = 0; l < L; l++)
            if (a != 0 && wb_we[l] && wb_addr[l*5 +: 5] == a) v = wb_data[l*X +: X];
        return v;
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 0) return 1'b0;
        foreach (infl[i]) if (infl[i].rd == r) return 1'b1;
        for (int l = 0; l < L; l++)
            if (m_valid && m_ld[l] && m_we[l] && m_rd[l*5 +: 5] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        bit hz = 1'b0;
        for (int l = 0; l < L; l++)
            if (id_lane_valid[l] && (pending(id_rj[l*5 +: 5]) || pending(id_rk[l*5 +: 5]))) hz = 1'b1;
        return ex_ready && !forward_stall && !hz;
    endfunction

    task automatic clear_ex();
        m_valid = 0; m_lv = '0; m_we = '0; m_ld = '0; m_pl = '0;
        m_rj = '0; m_rk = '0; m_rd = '0; m_jd = '0; m_kd = '0;
    endtask

    task automatic model_step();
        bit adv, take;
        logic [L*X-1:0] jd, kd;
        ld_t nq[$];
        adv = ex_ready && !forward_stall;
        take = id_valid && m_ready();
        for (int l = 0; l < L; l++) begin
            jd[l*X +: X] = read_reg(id_rj[l*5 +: 5]);
            kd[l*X +: X] = read_reg(id_rk[l*5 +: 5]);
        end
        if (reset) begin
            foreach (rf[i]) rf[i] = '0;
            infl.delete();
            clear_ex();
            return;
        end
        if (adv) begin
            foreach (infl[i]) if (infl[i].left > 1) nq.push_back('{infl[i].rd, infl[i].left - 1});
            for (int l = 0; l < L; l++)
                if (LL > 0 && m_lv[l] && m_ld[l] && m_we[l] && m_rd[l*5 +: 5] != 0)
                    nq.push_back('{m_rd[l*5 +: 5], LL});
            infl = nq;
        end
        if ((flush && (adv || !m_valid)) || (adv && !take)) clear_ex();
        else if (take) begin
            m_valid = 1; m_lv = id_lane_valid; m_pl = id_payload; m_rj = id_rj; m_rk = id_rk;
            m_rd = id_rd; m_we = id_we; m_ld = id_is_load; m_jd = jd; m_kd = kd;
        end else begin
            for (int l = 0; l < L; l++) begin
                if (fwd_j_valid[l]) m_jd[l*X +: X] = fwd_j_data[l*X +: X];
                if (fwd_k_valid[l]) m_kd[l*X +: X] = fwd_k_data[l*X +: X];
            end
        end
        for (int l = 0; l < L; l++)
            if (wb_we[l] && wb_addr[l*5 +: 5] != 0) rf[wb_addr[l*5 +: 5]] = wb_data[l*X +: X];
    endtask

    task automatic cycle();
        #1;
        chk("id_ready", id_ready, m_ready());
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_lane_valid", ex_lane_valid, m_lv);
        chk("ex_ctrl", {ex_rj, ex_rk, ex_rd, ex_we, ex_is_load}, {m_rj, m_rk, m_rd, m_we, m_ld});
        chk("ex_payload", ex_payload, m_pl);
        chk("ex_rj_data", ex_rj_data, m_jd);
        chk("ex_rk_data", ex_rk_data, m_kd);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; flush = 0; forward_stall = 0; ex_ready = 1; id_valid = 0;
        id_lane_valid = '0; id_payload = '0; id_rj = '0; id_rk = '0; id_rd = '0;
        id_we = '0; id_is_load = '0; fwd_j_valid = '0; fwd_k_valid = '0;
        fwd_j_data = '0; fwd_k_data = '0; wb_we = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic lane(input int l, input logic [4:0] rj, input logic [4:0] rk, input logic [4:0] rd,
                        input logic we, input logic ld);
        id_lane_valid[l] = 1'b1;
        id_rj[l*5 +: 5] = rj;
        id_rk[l*5 +: 5] = rk;
        id_rd[l*5 +: 5] = rd;
        id_we[l] = we;
        id_is_load[l] = ld;
        id_payload[l*P +: P] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        tbl[0] = '{5'd1, 5'd2, 32'd5, 32'd7};
        tbl[1] = '{5'd2, 5'd1, 32'd7, 32'd5};
        tbl[2] = '{5'd3, 5'd0, 32'h33, 32'd0};
        tbl[3] = '{5'd31, 5'd3, 32'hFFFF_FFFF, 32'h33};
        tbl[4] = '{5'd0, 5'd31, 32'd0, 32'hFFFF_FFFF};
        clear_ex();
        idle();
        reset = 1;
        repeat (2) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        idle();
        #1 chk("rst_id_ready", id_ready, 1'b1);
        chk("rst_ex_valid", {ex_valid, ex_lane_valid, ex_we, ex_is_load}, '0);
        chk("rst_ex_payload", ex_payload, '0);
        forward_stall = 1;
        #1 chk("rst_fstall_ready", id_ready, 1'b0);
        forward_stall = 0;
        cycle();

        wb_we = 2'b11; wb_addr = {5'd2, 5'd1}; wb_data = {32'd7, 32'd5}; cycle();
        wb_addr = {5'd31, 5'd3}; wb_data = {32'hFFFF_FFFF, 32'h33}; cycle();
        foreach (tbl[i]) begin
            idle(); id_valid = 1;
            lane(0, tbl[i].rj, tbl[i].rk, 5'd10, 1'b1, 1'b0);
            lane(1, tbl[i].rk, tbl[i].rj, 5'd11, 1'b1, 1'b0);
            cycle();
            chk("tbl_valid", ex_valid, 1'b1);
            chk("tbl_rj_data", ex_rj_data, {tbl[i].ek, tbl[i].ej});
            chk("tbl_rk_data", ex_rk_data, {tbl[i].ej, tbl[i].ek});
        end

        idle(); id_valid = 1; lane(0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1); cycle();
        idle(); id_valid = 1; lane(0, 5'd4, 5'd0, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lu_blocked", id_ready, 1'b0);
            cycle();
            chk("lu_bubble", {ex_valid, ex_lane_valid}, 3'b000);
        end
        #1 chk("lu_ready", id_ready, 1'b1);
        cycle();
        chk("lu_taken", {ex_valid, ex_lane_valid}, 3'b101);

        idle(); id_valid = 1; lane(0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); cycle();
        idle(); id_valid = 1; lane(0, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
        #1 chk("r0_no_stall", id_ready, 1'b1);
        cycle();

        idle(); id_valid = 1;
        lane(0, 5'd2, 5'd1, 5'd14, 1'b1, 1'b0);
        lane(1, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0);
        saved_pl = id_payload;
        cycle();
        idle(); ex_ready = 0; fwd_j_valid = 2'b10; fwd_j_data = {32'hDEAD_BEEF, 32'h1234}; cycle();
        chk("fwd_rj_data", ex_rj_data, {32'hDEAD_BEEF, 32'd7});
        chk("fwd_rk_data", ex_rk_data, {32'd7, 32'd5});
        chk("fwd_payload", ex_payload, saved_pl);
        chk("fwd_valid", {ex_valid, ex_lane_valid}, 3'b111);
        idle(); cycle();

        idle(); id_valid = 1; lane(0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1); cycle();
        idle(); id_valid = 1; lane(0, 5'd1, 5'd0, 5'd16, 1'b1, 1'b0); saved_pl = id_payload; cycle();
        idle(); ex_ready = 0; flush = 1; cycle();
        chk("flush_held_valid", ex_valid, 1'b1);
        chk("flush_held_payload", ex_payload, saved_pl);
        idle(); flush = 1; cycle();
        chk("flush_cleared", {ex_valid, ex_lane_valid}, 3'b000);
        chk("flush_cleared_payload", ex_payload, '0);
        idle(); id_valid = 1; lane(0, 5'd6, 5'd0, 5'd17, 1'b1, 1'b0);
        #1 chk("flush_sb_block", id_ready, 1'b0);
        cycle();
        #1 chk("flush_sb_release", id_ready, 1'b1);
        cycle();

        idle(); wb_we = 2'b11; wb_addr = {5'd9, 5'd9}; wb_data = {32'h22, 32'h11};
        id_valid = 1; lane(0, 5'd9, 5'd0, 5'd18, 1'b1, 1'b0); cycle();
        chk("dual_wb_bypass", ex_rj_data[31:0], 32'h22);
        idle(); id_valid = 1; lane(0, 5'd0, 5'd9, 5'd18, 1'b1, 1'b0); cycle();
        chk("dual_wb_stored", ex_rk_data[31:0], 32'h22);

        for (int i = 0; i < 400; i++) begin
            idle();
            reset = ($urandom_range(63) == 0);
            flush = ($urandom_range(9) == 0);
            forward_stall = ($urandom_range(5) == 0);
            ex_ready = ($urandom_range(3) != 0);
            id_valid = 1'($urandom_range(1));
            for (int l = 0; l < L; l++) begin
                if ($urandom_range(3) != 0)
                    lane(l, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                         1'($urandom_range(1)), 1'($urandom_range(1)));
                wb_addr[l*5 +: 5] = 5'($urandom_range(7));
            end
            fwd_j_valid = L'($urandom); fwd_k_valid = L'($urandom);
            fwd_j_data = {$urandom, $urandom}; fwd_k_data = {$urandom, $urandom};
            wb_we = L'($urandom); wb_data = {$urandom, $urandom};
            cycle();
        end
        idle();
        cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_ex_issue_stage.md
# reg_ex_issue_stage

Parametrised ID→EX pipeline register with an embedded multi-port register file, a configurable-depth load-use scoreboard and in-place operand forwarding while stalled. It generalises the dual-lane operand-read stage to `LANES` issue lanes and a `LOAD_LAT`-deep load shadow. Explicit valid bits replace the old inst-NOP bubbles. It sits between the decode queue (ID) and the EX1 stage of the in-order core.

## Interface
- `LANES`, 2, issue lanes per bundle (1..4)
- `XLEN`, 32, data width
- `PAYLOAD_W`, 160, opaque per-lane payload (pc, inst, uop, imm, exception bits), passed through untouched
- `LOAD_LAT`, 2, cycles after EX during which a load result is not forwardable (0..4)
- `clk` in 1, clock
- `reset` in 1, one clock; reset is synchronous and active-high
- `flush` in 1, kill EX-register contents (priv/branch redirect)
- `forward_stall` in 1, downstream forwarding network not ready; freezes EX register
- `id_valid` in 1 / `id_ready` out 1, ID→stage handshake (bundle granularity)
- `id_lane_valid` in LANES, per-lane valid within bundle
- `id_payload` in LANES*PAYLOAD_W; `id_rj`, `id_rk`, `id_rd` in LANES*5; `id_we`, `id_is_load` in LANES
- `ex_valid` out 1 / `ex_ready` in 1, stage→EX handshake
- `ex_lane_valid` out LANES; `ex_payload` out LANES*PAYLOAD_W; `ex_rj`, `ex_rk`, `ex_rd` out LANES*5; `ex_we`, `ex_is_load` out LANES
- `ex_rj_data`, `ex_rk_data` out LANES*XLEN, captured operands
- `fwd_j_valid`, `fwd_k_valid` in LANES; `fwd_j_data`, `fwd_k_data` in LANES*XLEN, late forwarding into held operands
- `wb_we` in LANES; `wb_addr` in LANES*5; `wb_data` in LANES*XLEN, register-file write ports

## Operation
- `adv = ex_ready & ~forward_stall`; `hazard` as below; `id_ready = adv & ~hazard`; `take = id_valid & id_ready`.
- Register file: 32×XLEN, 2·LANES comb read ports, LANES write ports. r0 reads 0 and ignores writes. Write-first bypass: a same-cycle write to a read address returns `wb_data`. Multiple writes to the same address: highest lane index wins.
- EX register update priority:
  1. `reset`, or `flush & adv`, or `flush & ~ex_valid`: clear all (ex_valid=0, lane_valid=0, payload/rd/rj/rk/data=0, we/is_load=0).
  2. `take`: load all ID fields, lane_valid=id_lane_valid, operands from register file.
  3. `adv & ~take`: insert bubble (ex_valid=0, lane_valid=0, we/is_load=0; other fields cleared).
  4. Otherwise hold. Each held operand is replaced by `fwd_*_data` when its `fwd_*_valid` is high.
- `flush` while `~adv` and ex_valid: contents held until `adv`, then cleared. `flush` takes precedence over `take`.
- Scoreboard: `LOAD_LAT` stages × LANES entries {v, rd}. On `adv`: stage0 ← {ex_lane_valid & ex_is_load & ex_we & (ex_rd≠0), ex_rd}; stage k ← stage k-1. Entries are held when `~adv`. Reset clears all. Flush does not clear: older loads remain in flight. With `LOAD_LAT=0` the scoreboard is absent.
- `hazard` = any ID lane with id_lane_valid whose nonzero rj or rk equals the rd of any valid scoreboard entry, or of any EX lane with ex_valid, ex_is_load and ex_we. Comparisons ignore register 0.
- Intra-bundle dependencies are the decoder's responsibility and are not checked.

## Timing
- ID→EX latency: 1 cycle. Operands are sampled at the `take` edge.
- `id_ready`, `hazard`: combinational from ID fields, EX register, scoreboard, `ex_ready`, `forward_stall`. There is no comb path from `id_valid`.
- Reset values: all outputs 0. `id_ready` = `ex_ready & ~forward_stall` (scoreboard empty).
- Load in EX at cycle t with `adv`: a dependent instruction is blocked during t..t+LOAD_LAT, and may take at cycle t+LOAD_LAT+1, given continuous `adv`.
- Stalls extend the window cycle-for-cycle, because the scoreboard only shifts on `adv`.

## Structure
- Shared package `cpu_pipe_pkg`: lane field offsets, `REG_ZERO`, and the default `LOAD_LAT`/`PAYLOAD_W` values.
- Sub-module `regfile_mp` (parametrised LANES write/2·LANES read, write-first, lane-priority). The scoreboard stays inline.

## Test plan
- Reset, then a bundle with r1=5 and r2=7 loaded via wb: `take` gives ex_rj_data=5, ex_rk_data=7, ex_valid=1 next cycle.
- Load rd=4 in EX, next ID reads rj=4, LOAD_LAT=2, adv=1: id_ready=0 for 3 cycles, take on the 4th. EX shows 3 bubbles with lane_valid=0.
- ID reads r0 while an EX load has rd=0: no stall.
- Hold with ex_ready=0, fwd_j_valid[1]=1, data=0xDEAD_BEEF: ex_rj_data[lane1]=0xDEADBEEF next cycle, all other fields unchanged.
- flush with ex_ready=0, then ex_ready=1: EX held, then cleared. A scoreboard load issued before the flush still blocks its dependent.
- wb lanes 0 and 1 both write r9 (0x11, 0x22) while ID reads r9: captured 0x22, and a later read returns 0x22.
